// File: rtl/memory_bank.sv
// Multi-word storage: DEPTH words of WIDTH bits, one write port, two independent
// combinational read ports, bulk clear and per-word written flags.
module memory_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter bit          BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save,
    input  logic [ADDR_W-1:0] save_addr,
    input  logic [WIDTH-1:0]  value,
    input  logic              clear,
    input  logic              load0,
    input  logic [ADDR_W-1:0] load_addr0,
    output logic [WIDTH-1:0]  out0,
    output logic              valid0,
    input  logic              load1,
    input  logic [ADDR_W-1:0] load_addr1,
    output logic [WIDTH-1:0]  out1,
    output logic              valid1
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] wr_flag_q;
    logic [DEPTH-1:0] wr_flag_d;

    logic save_in_range;
    logic bypass_ok;

    assign save_in_range = 32'(save_addr) < DEPTH;
    assign bypass_ok     = BYPASS && save && save_in_range && !rst && !clear;

    // Addresses are decoded by comparison so out-of-range addresses match no word.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_flag_d = wr_flag_q;
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_flag_d = '0;
        end else if (save) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (32'(save_addr) == i) begin
                    mem_d[i]     = value;
                    wr_flag_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_flag_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_flag_q <= wr_flag_d;
        end
    end

    always_comb begin
        out0   = '0;
        valid0 = 1'b0;
        if (load0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (32'(load_addr0) == i) begin
                    out0   = mem_q[i];
                    valid0 = wr_flag_q[i];
                end
            end
            if (bypass_ok && (load_addr0 == save_addr)) begin
                out0   = value;
                valid0 = 1'b1;
            end
        end
    end

    always_comb begin
        out1   = '0;
        valid1 = 1'b0;
        if (load1) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (32'(load_addr1) == i) begin
                    out1   = mem_q[i];
                    valid1 = wr_flag_q[i];
                end
            end
            if (bypass_ok && (load_addr1 == save_addr)) begin
                out1   = value;
                valid1 = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_bank.sv
// Directed table-driven bench: three instances (plain, bypass, DEPTH=3) share
// the same stimulus; each row carries hand-computed outputs for every instance.
module tb_memory_bank;

    logic       clk = 1'b0;
    logic       rst, save, clear, load0, load1;
    logic [1:0] save_addr, load_addr0, load_addr1;
    logic [7:0] value;

    logic [7:0] a_out0, a_out1, b_out0, b_out1, c_out0, c_out1;
    logic       a_v0, a_v1, b_v0, b_v1, c_v0, c_v1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    memory_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BYPASS(1'b0)) u_plain (
        .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .value(value),
        .clear(clear), .load0(load0), .load_addr0(load_addr0), .out0(a_out0), .valid0(a_v0),
        .load1(load1), .load_addr1(load_addr1), .out1(a_out1), .valid1(a_v1)
    );

    memory_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .BYPASS(1'b1)) u_bypass (
        .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .value(value),
        .clear(clear), .load0(load0), .load_addr0(load_addr0), .out0(b_out0), .valid0(b_v0),
        .load1(load1), .load_addr1(load_addr1), .out1(b_out1), .valid1(b_v1)
    );

    memory_bank #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .BYPASS(1'b0)) u_depth3 (
        .clk(clk), .rst(rst), .save(save), .save_addr(save_addr), .value(value),
        .clear(clear), .load0(load0), .load_addr0(load_addr0), .out0(c_out0), .valid0(c_v0),
        .load1(load1), .load_addr1(load_addr1), .out1(c_out1), .valid1(c_v1)
    );

    // Packed expectation: {out0, valid0, out1, valid1}
    typedef logic [17:0] exp_t;

    typedef struct {
        bit         chk;
        logic       rst, save, clear, load0, load1;
        logic [1:0] save_addr, load_addr0, load_addr1;
        logic [7:0] value;
        exp_t       ea, eb, ec;
    } vec_t;

    vec_t vecs[$];

    function automatic exp_t e(input logic [7:0] o0, input logic v0,
                               input logic [7:0] o1, input logic v1);
        return {o0, v0, o1, v1};
    endfunction

    task automatic add(input bit chk, input logic r, input logic s, input logic [1:0] sa,
                       input logic [7:0] val, input logic clr,
                       input logic l0, input logic [1:0] a0, input logic l1, input logic [1:0] a1,
                       input exp_t ea, input exp_t eb, input exp_t ec);
        vec_t v;
        v.chk = chk; v.rst = r; v.save = s; v.save_addr = sa; v.value = val; v.clear = clr;
        v.load0 = l0; v.load_addr0 = a0; v.load1 = l1; v.load_addr1 = a1;
        v.ea = ea; v.eb = eb; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] sa,
                         input logic [7:0] val, input logic clr,
                         input logic l0, input logic [1:0] a0, input logic l1,
                         input logic [1:0] a1);
        rst = r; save = s; save_addr = sa; value = val; clear = clr;
        load0 = l0; load_addr0 = a0; load1 = l1; load_addr1 = a1;
    endtask

    task automatic check(input string name, input exp_t got, input exp_t exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got out0=%h v0=%b out1=%h v1=%b, want out0=%h v0=%b out1=%h v1=%b",
                      name, got[17:10], got[9], got[8:1], got[0],
                      exp[17:10], exp[9], exp[8:1], exp[0]);
    endtask

    task automatic check_all(input string tag, input exp_t ea, input exp_t eb, input exp_t ec);
        check({tag, " plain"},  {a_out0, a_v0, a_out1, a_v1}, ea);
        check({tag, " bypass"}, {b_out0, b_v0, b_out1, b_v1}, eb);
        check({tag, " depth3"}, {c_out0, c_v0, c_out1, c_v1}, ec);
    endtask

    exp_t z;

    initial begin
        z = e(8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

        //  chk rst sav sa  val   clr l0 a0 l1 a1
        add(0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 1, z, z, z);
        add(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 1, z, z, z);
        add(1, 0, 0, 0, 8'h00, 0, 1, 2, 1, 3, z, z, z);
        add(1, 0, 1, 2, 8'hA5, 0, 1, 2, 1, 1, z, e(8'hA5, 1, 0, 0), z);
        add(1, 0, 0, 0, 8'h00, 0, 1, 2, 1, 1,
            e(8'hA5, 1, 0, 0), e(8'hA5, 1, 0, 0), e(8'hA5, 1, 0, 0));
        add(1, 0, 1, 1, 8'h3C, 0, 1, 1, 1, 2,
            e(0, 0, 8'hA5, 1), e(8'h3C, 1, 8'hA5, 1), e(0, 0, 8'hA5, 1));
        add(1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 1,
            e(8'h3C, 1, 8'h3C, 1), e(8'h3C, 1, 8'h3C, 1), e(8'h3C, 1, 8'h3C, 1));
        add(1, 0, 1, 0, 8'h11, 0, 0, 2, 1, 0, z, e(0, 0, 8'h11, 1), z);
        add(1, 0, 1, 1, 8'h22, 0, 1, 1, 1, 0,
            e(8'h3C, 1, 8'h11, 1), e(8'h22, 1, 8'h11, 1), e(8'h3C, 1, 8'h11, 1));
        add(1, 0, 1, 3, 8'h33, 0, 1, 1, 1, 3,
            e(8'h22, 1, 0, 0), e(8'h22, 1, 8'h33, 1), e(8'h22, 1, 0, 0));
        add(1, 0, 1, 2, 8'h44, 1, 1, 3, 1, 2,
            e(8'h33, 1, 8'hA5, 1), e(8'h33, 1, 8'hA5, 1), e(0, 0, 8'hA5, 1));
        add(1, 0, 0, 0, 8'h00, 0, 1, 2, 1, 3, z, z, z);
        add(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 1, z, z, z);
        add(1, 0, 1, 0, 8'h77, 0, 1, 0, 0, 0, z, e(8'h77, 1, 0, 0), z);
        add(1, 0, 1, 0, 8'h77, 0, 1, 0, 0, 0,
            e(8'h77, 1, 0, 0), e(8'h77, 1, 0, 0), e(8'h77, 1, 0, 0));
        add(1, 1, 1, 0, 8'h77, 0, 1, 0, 0, 0,
            e(8'h77, 1, 0, 0), e(8'h77, 1, 0, 0), e(8'h77, 1, 0, 0));
        add(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, z, z, z);
        add(1, 0, 1, 0, 8'h77, 0, 1, 0, 0, 0, z, e(8'h77, 1, 0, 0), z);
        add(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0,
            e(8'h77, 1, 8'h77, 1), e(8'h77, 1, 8'h77, 1), e(8'h77, 1, 8'h77, 1));
        add(1, 0, 1, 1, 8'h22, 0, 1, 1, 1, 3, z, e(8'h22, 1, 0, 0), z);
        add(1, 0, 1, 3, 8'hFF, 0, 1, 3, 1, 1,
            e(0, 0, 8'h22, 1), e(8'hFF, 1, 8'h22, 1), e(0, 0, 8'h22, 1));
        add(1, 0, 0, 0, 8'h00, 0, 1, 3, 1, 1,
            e(8'hFF, 1, 8'h22, 1), e(8'hFF, 1, 8'h22, 1), e(0, 0, 8'h22, 1));
        add(1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0,
            e(0, 0, 8'h77, 1), e(0, 0, 8'h77, 1), e(0, 0, 8'h77, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].save, vecs[i].save_addr, vecs[i].value, vecs[i].clear,
                  vecs[i].load0, vecs[i].load_addr0, vecs[i].load1, vecs[i].load_addr1);
            #2;
            if (vecs[i].chk) check_all($sformatf("row%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec);
        end

        // Save, then a save colliding with clear, then a save colliding with rst.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd2, 8'h6B, 1'b1, 1'b1, 2'd2, 1'b1, 2'd1);
        #2;
        check_all("clr_save_cycle", e(8'h5A, 1, 8'h22, 1), e(8'h5A, 1, 8'h22, 1),
                  e(8'h5A, 1, 8'h22, 1));
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1, 2'd1);
        #2;
        check_all("after_clear", z, z, z);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd1, 8'h9C, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd1, 8'hC3, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1);
        #2;
        check_all("rst_save_cycle", e(8'h9C, 1, 8'h9C, 1), e(8'h9C, 1, 8'h9C, 1),
                  e(8'h9C, 1, 8'h9C, 1));
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1);
        #2;
        check_all("after_rst", z, z, z);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
